// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then one 32-bit column
// per cycle through AddRoundKey and ten inverse rounds, with the inverse key schedule run alongside.
module aes128_decrypt (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_ADDK   = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) xor the round constant in the top byte.
    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
        return {SBOX[w[23:16]] ^ rc, SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ g_word(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ g_word(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_e        st_q;
    logic [127:0]  state_q, nxt_q, rk_q, dout_q;
    logic [3:0]    rnd_q;
    logic [1:0]    c_q;
    logic          busy_q, done_q;

    logic [31:0]   st_w [4];
    logic [31:0]   rk_w [4];
    logic [31:0]   nx_w [4];
    logic [1:0]    src_c;
    logic [31:0]   t_col, round_col, new_col;
    logic [127:0]  nxt_d, rk_fwd_d, rk_inv_d;

    // Column c of the next state always reads the full, unmodified state_q.
    always_comb begin
        src_c = 2'd0;
        t_col = 32'h0;
        for (int i = 0; i < 4; i++) begin
            st_w[i] = state_q[127-32*i -: 32];
            rk_w[i] = rk_q[127-32*i -: 32];
        end
        for (int r = 0; r < 4; r++) begin
            src_c = c_q - 2'(r);
            t_col[31-8*r -: 8] = ISBOX[st_w[src_c][31-8*r -: 8]] ^ rk_w[c_q][31-8*r -: 8];
        end
        round_col = (rnd_q == 4'd0) ? t_col : inv_mix(t_col);
        new_col   = (st_q == S_ADDK) ? (st_w[c_q] ^ rk_w[c_q]) : round_col;
        for (int i = 0; i < 4; i++) begin
            nx_w[i] = (2'(i) == c_q) ? new_col : nxt_q[127-32*i -: 32];
        end
        nxt_d    = {nx_w[0], nx_w[1], nx_w[2], nx_w[3]};
        rk_fwd_d = key_fwd(rk_q, rcon(rnd_q));
        rk_inv_d = key_inv(rk_q, rcon(rnd_q - 4'd1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q    <= S_IDLE;
            c_q     <= 2'd0;
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 128'h0;
            state_q <= 128'h0;
            nxt_q   <= 128'h0;
            rk_q    <= 128'h0;
        end else if (ce) begin
            case (st_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= data_in;
                        rk_q    <= key;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        rnd_q   <= 4'd0;
                        c_q     <= 2'd0;
                        st_q    <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    rk_q  <= rk_fwd_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'd9) st_q <= S_ADDK;
                end
                S_ADDK: begin
                    nxt_q <= nxt_d;
                    c_q   <= c_q + 2'd1;
                    if (c_q == 2'd3) begin
                        state_q <= nxt_d;
                        rk_q    <= rk_inv_d;
                        rnd_q   <= 4'd9;
                        st_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    nxt_q <= nxt_d;
                    c_q   <= c_q + 2'd1;
                    if (c_q == 2'd3) begin
                        state_q <= nxt_d;
                        if (rnd_q != 4'd0) begin
                            rnd_q <= rnd_q - 4'd1;
                            rk_q  <= rk_inv_d;
                        end else begin
                            dout_q <= nxt_d;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            st_q   <= S_DONE;
                        end
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign data_out  = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = st_q;

endmodule
